// File: rtl/core_pkg.sv
// Shared core constants and types for the register file and its scoreboard.
package core_pkg;

    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int SB_CNT_W   = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/core_sb.sv
// Pending-write scoreboard: one saturating counter per register, issue
// back-pressure and busy lookups for the two read ports.
// Optional macro CORE_RF_BYPASS_EN: a same-cycle write that retires the last
// pending claim clears the busy flag combinationally.
module core_sb
    import core_pkg::*;
#(
    parameter int REG_NUM  = core_pkg::REG_NUM,
    parameter int SB_CNT_W = core_pkg::SB_CNT_W
) (
    input  logic                  clk,
    input  logic                  rest,
    input  logic                  i_flush,
    input  logic                  i_iss_valid,
    input  logic [REG_ADDR_W-1:0] i_iss_rd,
    output logic                  o_iss_ready,
    input  logic                  i_wr_en,
    input  logic [REG_ADDR_W-1:0] i_wr_rd,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy
);

    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);

    logic [SB_CNT_W-1:0] r_cnt [REG_NUM];
    logic                w_wr_same;
    logic                w_iss_fire;
    logic                w_rs1_clr;
    logic                w_rs2_clr;

    // Issue stalls only when the target counter is full and nothing retires it this cycle
    always_comb begin
        w_wr_same   = i_wr_en && (i_wr_rd == i_iss_rd);
        o_iss_ready = !rest || (i_iss_rd == '0) ||
                      (r_cnt[i_iss_rd] != CNT_MAX) || w_wr_same;
        w_iss_fire  = i_iss_valid && o_iss_ready && !i_flush && (i_iss_rd != '0);
    end

    genvar g;
    generate
        for (g = 0; g < REG_NUM; g++) begin : g_cnt
            localparam logic [REG_ADDR_W-1:0] IDX = REG_ADDR_W'(g);
            logic w_inc;
            logic w_dec;
            assign w_inc = w_iss_fire && (i_iss_rd == IDX);
            assign w_dec = i_wr_en && (i_wr_rd == IDX);

            // Counter update; coincident issue and retire cancel, retire saturates at 0
            always_ff @(posedge clk) begin
                if (!rest || i_flush) begin
                    r_cnt[g] <= '0;
                end else if (w_inc && !w_dec) begin
                    r_cnt[g] <= r_cnt[g] + CNT_ONE;
                end else if (w_dec && !w_inc && (r_cnt[g] != '0)) begin
                    r_cnt[g] <= r_cnt[g] - CNT_ONE;
                end
            end
        end
    endgenerate

    // Busy lookups, optionally cleared by a write retiring the last claim
    always_comb begin
`ifdef CORE_RF_BYPASS_EN
        w_rs1_clr = i_wr_en && (i_wr_rd == i_rs1_addr) && (r_cnt[i_rs1_addr] == CNT_ONE) &&
                    !(w_iss_fire && (i_iss_rd == i_rs1_addr));
        w_rs2_clr = i_wr_en && (i_wr_rd == i_rs2_addr) && (r_cnt[i_rs2_addr] == CNT_ONE) &&
                    !(w_iss_fire && (i_iss_rd == i_rs2_addr));
`else
        w_rs1_clr = 1'b0;
        w_rs2_clr = 1'b0;
`endif
        o_rs1_busy = rest && (r_cnt[i_rs1_addr] != '0) && !w_rs1_clr;
        o_rs2_busy = rest && (r_cnt[i_rs2_addr] != '0) && !w_rs2_clr;
    end

endmodule

// File: rtl/core_regfile.sv
// Integer register file and write-back sink with two combinational read ports
// and a pending-write scoreboard (core_sb) for decode hazard detection.
// Optional macro CORE_RF_BYPASS_EN: forwards same-cycle write data to reads.
module core_regfile
    import core_pkg::*;
#(
    parameter int REG_NUM  = core_pkg::REG_NUM,
    parameter int SB_CNT_W = core_pkg::SB_CNT_W
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [31:0] wb_reg_data,
    input  logic [4:0]  wb_rd,
    input  logic        wb_reg_write,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic        iss_ready,
    input  logic        flush,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic        rs1_busy,
    output logic        rs2_busy
);

    xlen_t r_regs [REG_NUM];
    logic  w_wr_hs;
    xlen_t w_rs1_data;
    xlen_t w_rs2_data;

    // The sink never stalls; it is only unready while held in reset
    assign wb_ready = rest;
    assign w_wr_hs  = wb_valid && wb_ready && wb_reg_write;

    // Register array; x0 is never written so it stays zero
    always_ff @(posedge clk) begin
        if (!rest) begin
            for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
        end else if (w_wr_hs && (wb_rd != '0)) begin
            r_regs[wb_rd] <= wb_reg_data;
        end
    end

    // Read muxes with optional forwarding of the in-flight write
    always_comb begin
        w_rs1_data = (rs1_addr == '0) ? '0 : r_regs[rs1_addr];
        w_rs2_data = (rs2_addr == '0) ? '0 : r_regs[rs2_addr];
`ifdef CORE_RF_BYPASS_EN
        if (w_wr_hs && (wb_rd != '0) && (wb_rd == rs1_addr)) w_rs1_data = wb_reg_data;
        if (w_wr_hs && (wb_rd != '0) && (wb_rd == rs2_addr)) w_rs2_data = wb_reg_data;
`endif
        rs1_data = rest ? w_rs1_data : '0;
        rs2_data = rest ? w_rs2_data : '0;
    end

    core_sb #(
        .REG_NUM  (REG_NUM),
        .SB_CNT_W (SB_CNT_W)
    ) u_sb (
        .clk         (clk),
        .rest        (rest),
        .i_flush     (flush),
        .i_iss_valid (iss_valid),
        .i_iss_rd    (iss_rd),
        .o_iss_ready (iss_ready),
        .i_wr_en     (w_wr_hs),
        .i_wr_rd     (wb_rd),
        .i_rs1_addr  (rs1_addr),
        .i_rs2_addr  (rs2_addr),
        .o_rs1_busy  (rs1_busy),
        .o_rs2_busy  (rs2_busy)
    );

endmodule

// File: tb/tb_core_regfile.sv
// Directed bench for core_regfile: expected values are queued as stimulus is
// driven and popped when the corresponding output is sampled.
module tb_core_regfile;

    logic        clk = 1'b0;
    logic        rest;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_reg_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic        flush;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;

    int n_pass = 0;
    int n_chk  = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    core_regfile dut (
        .clk          (clk),
        .rest         (rest),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_reg_data  (wb_reg_data),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .iss_valid    (iss_valid),
        .iss_rd       (iss_rd),
        .iss_ready    (iss_ready),
        .flush        (flush),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        n_chk++;
        assert (obs === e) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", t, obs, e);
    endtask

    task automatic wr(input logic [4:0] rd, input logic [31:0] d);
        wb_valid     = 1'b1;
        wb_reg_write = 1'b1;
        wb_rd        = rd;
        wb_reg_data  = d;
    endtask

    task automatic wr_off();
        wb_valid     = 1'b0;
        wb_reg_write = 1'b0;
    endtask

    initial begin
        rest = 1'b0; wb_valid = 1'b0; wb_reg_data = '0; wb_rd = '0; wb_reg_write = 1'b0;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0; rs1_addr = 5'd5; rs2_addr = '0;

        // reset held for two edges
        tick(); tick();
        push("rst_wb_ready", 32'd0);  chk({31'd0, wb_ready});
        push("rst_iss_ready", 32'd1); chk({31'd0, iss_ready});
        push("rst_busy", 32'd0);      chk({31'd0, rs1_busy});
        push("rst_data", 32'd0);      chk(rs1_data);
        rest = 1'b1;
        #1;
        push("wb_ready_after", 32'd1); chk({31'd0, wb_ready});
        for (int a = 0; a < 32; a++) begin
            rs1_addr = a[4:0];
            #1;
            push($sformatf("rst_rd_x%0d", a), 32'd0); chk(rs1_data);
            push($sformatf("rst_busy_x%0d", a), 32'd0); chk({31'd0, rs1_busy});
            tick();
        end

        // write / read, including discarded write to x0
        wr(5'd5, 32'hDEADBEEF); push("rd_x5", 32'hDEADBEEF);
        tick(); wr_off(); rs1_addr = 5'd5; #1; chk(rs1_data);
        wr(5'd0, 32'h1234); push("rd_x0", 32'd0);
        tick(); wr_off(); rs1_addr = 5'd0; #1; chk(rs1_data);
        push("busy_x0", 32'd0); chk({31'd0, rs1_busy});

        // scoreboard count up to 2 then retire
        rs2_addr = 5'd7; iss_valid = 1'b1; iss_rd = 5'd7;
        push("iss_to_busy", 32'd1);
        tick(); chk({31'd0, rs2_busy});
        tick(); iss_valid = 1'b0; #1;
        push("busy_cnt2", 32'd1); chk({31'd0, rs2_busy});
        wr(5'd7, 32'h7); push("busy_after_wr1", 32'd1);
        tick(); wr_off(); #1; chk({31'd0, rs2_busy});
        wr(5'd7, 32'h77); push("busy_after_wr2", 32'd0);
        tick(); wr_off(); #1; chk({31'd0, rs2_busy});

        // saturation at 3 claims
        iss_valid = 1'b1; iss_rd = 5'd3;
        for (int k = 0; k < 3; k++) begin
            #1; push($sformatf("sat_ready_%0d", k), 32'd1); chk({31'd0, iss_ready});
            tick();
        end
        push("sat_full", 32'd0); chk({31'd0, iss_ready});
        wr(5'd3, 32'h3); #1;
        push("sat_with_wr", 32'd1); chk({31'd0, iss_ready});
        tick(); wr_off(); #1;
        push("sat_cnt_kept", 32'd0); chk({31'd0, iss_ready});
        iss_valid = 1'b0;

        // flush clears claims; later write has no underflow
        iss_valid = 1'b1; iss_rd = 5'd9; rs1_addr = 5'd9;
        tick(); iss_valid = 1'b0; flush = 1'b1; #1;
        push("busy_pre_flush", 32'd1); chk({31'd0, rs1_busy});
        tick(); flush = 1'b0; #1;
        push("busy_post_flush", 32'd0); chk({31'd0, rs1_busy});
        iss_rd = 5'd3; #1;
        push("flush_clr_x3", 32'd1); chk({31'd0, iss_ready});
        wr(5'd9, 32'h55); push("rd_x9", 32'h55);
        tick(); wr_off(); #1; chk(rs1_data);
        push("busy_x9_zero", 32'd0); chk({31'd0, rs1_busy});
        iss_valid = 1'b1; iss_rd = 5'd9; push("no_underflow", 32'd1);
        tick(); iss_valid = 1'b0; #1; chk({31'd0, rs1_busy});

        // flush beats a same-cycle issue
        rs2_addr = 5'd10; iss_valid = 1'b1; iss_rd = 5'd10; flush = 1'b1;
        push("flush_over_iss", 32'd0);
        tick(); iss_valid = 1'b0; flush = 1'b0; #1; chk({31'd0, rs2_busy});

        // same-cycle read of a register being written
        wr(5'd12, 32'h11111111);
        tick(); wr_off();
        rs1_addr = 5'd12; wr(5'd12, 32'hA5A5A5A5); #1;
`ifdef CORE_RF_BYPASS_EN
        push("bypass_same", 32'hA5A5A5A5);
`else
        push("bypass_same", 32'h11111111);
`endif
        chk(rs1_data);
        tick(); wr_off(); #1;
        push("bypass_next", 32'hA5A5A5A5); chk(rs1_data);

        // reset mid-operation wipes data and claims
        rest = 1'b0; tick(); rest = 1'b1;
        rs1_addr = 5'd5; rs2_addr = 5'd9; #1;
        push("mid_rst_data", 32'd0); chk(rs1_data);
        push("mid_rst_busy", 32'd0); chk({31'd0, rs2_busy});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/core_regfile.md
# core_regfile

Integer register file and write-back sink for the core pipeline. It is the receiving end of the write-back interface: it accepts `wb_*` register writes from the write-back stage and serves two combinational read ports to the decode stage. A per-register pending-write scoreboard lets decode detect and stall on hazards. The block lives alongside the decode stage, and `wb_ready` returns to the write-back stage.

## Interface
Parameters:
- `REG_NUM`, 32: number of architectural registers. Register x0 is hardwired to zero.
- `SB_CNT_W`, 2: width of each scoreboard counter. This sets the maximum number of in-flight writes per register to 2^SB_CNT_W−1.

Ports:
- `clk`  in  1  the single clock. Everything is on the rising edge.
- `rest`  in  1  reset, synchronous and active-low.
- `wb_valid`  in  1  the write-back beat is valid.
- `wb_ready`  out  1  the sink can accept a write-back beat.
- `wb_reg_data`  in  32  write data.
- `wb_rd`  in  5  destination register.
- `wb_reg_write`  in  1  register write enable. It is already qualified by valid upstream.
- `iss_valid`  in  1  decode is issuing an instruction that will write `iss_rd`.
- `iss_rd`  in  5  destination register of the issuing instruction.
- `iss_ready`  out  1  the issue may be claimed this cycle.
- `flush`  in  1  pipeline flush. It clears all pending claims.
- `rs1_addr`, `rs2_addr`  in  5  read addresses.
- `rs1_data`, `rs2_data`  out  32  read data.
- `rs1_busy`, `rs2_busy`  out  1  the addressed register has a pending write.

## Operation
- **Write.** On a handshake (`wb_valid && wb_ready && wb_reg_write`) with `wb_rd != 0`, `wb_reg_data` is written into `wb_rd` at the clock edge. Writes to x0 are discarded.
- **Read.** Reads are combinational. Address 0 always returns 0 with busy 0.
- **Scoreboard.** Each register has one unsigned counter of `SB_CNT_W` bits.
  - An issue (`iss_valid && iss_ready`, with `iss_rd != 0`) increments the counter for `iss_rd`.
  - A write handshake decrements the counter for `wb_rd`.
  - The decrement saturates at 0. A write arriving after a flush with counter 0 still updates the register file.
- **Simultaneous issue and write to the same rd.** The counter is unchanged.
- **Issue saturation.** `iss_ready` = 0 when the counter for `iss_rd` is at its maximum and no write to that register completes this cycle. Otherwise `iss_ready` = 1. Issue to x0 is always ready.
- **Busy.** `rsN_busy` = (counter[rsN_addr] != 0), evaluated before this cycle's update, except where the bypass clears it (see Configuration).
- **Flush.** A flush zeroes all counters at the edge and overrides any same-cycle issue. A same-cycle write-back still writes the register file.
- **Back-pressure.** `wb_ready` is 1 whenever `rest` is high, so writes are never stalled.

## Timing
- **Reset.**
  - While `rest` is low at an edge, all registers go to 0 and all counters go to 0.
  - Outputs during and after reset: `wb_ready` = 0 while `rest` is low; `iss_ready` = 1; `rsN_data` = 0; `rsN_busy` = 0.
  - A reset asserted mid-operation discards pending claims, and register contents return to 0.
- **Latencies.**
  - Write-to-read latency is 1 cycle: a write at edge N is visible on the read ports after N.
  - Issue-to-busy latency is 1 cycle.
  - Write-to-unbusy latency is 1 cycle.
- **Handshake.** A beat transfers on any edge with `wb_valid && wb_ready`. No beat is held across cycles.

## Configuration
- **`CORE_RF_BYPASS_EN` defined.**
  - When a write handshake targets `rsN_addr` (non-zero) in the same cycle, `rsN_data` = `wb_reg_data` combinationally.
  - `rsN_busy` is cleared if this write drops the counter to 0.
  - Effective write-to-read latency is 0.
- **Not defined.**
  - Reads return the stored value only.
  - Busy reflects the registered counter.
  - Decode therefore stalls one extra cycle.

## Structure
- **Shared package `core_pkg`.**
  - Constants: `REG_NUM`, `REG_ADDR_W` = 5, `XLEN` = 32, `SB_CNT_W`.
  - Typedef: `reg_addr_t` (5-bit).
  - Typedef: `xlen_t` (32-bit).
- **One sub-module, `core_sb`.** It holds the scoreboard counter array, the `iss_ready` logic, the flush clear and the busy lookups. The register array and the read/bypass muxes stay in `core_regfile`.

## Test plan
- **Reset.** Hold `rest`=0 for 2 cycles, then release. Required: `rs1_data`=0 for all addresses, `rs1_busy`=0, `iss_ready`=1, `wb_ready`=1 after release.
- **Write/read.** Write x5=0xDEADBEEF. Required: the next cycle `rs1_addr`=5 gives 0xDEADBEEF. Writing x0=0x1234 must read back 0.
- **Scoreboard.** Issue rd=7 twice, so the counter is 2. Required: `rs2_busy`=1. After one write to x7, busy is still 1. After the second write, busy is 0.
- **Saturation.** With `SB_CNT_W`=2, issue rd=3 three times. Required: the fourth issue sees `iss_ready`=0. With the fourth issue and a write to x3 in the same cycle, `iss_ready`=1 and the counter stays at 3.
- **Flush.** Issue rd=9, flush, then write x9=0x55. Required: busy is 0 after the flush, the counter stays 0 (no underflow), and reading x9 gives 0x55.
- **Bypass.** Write x12=0xA5A5A5A5 with `rs1_addr`=12 in the same cycle. Required: with `CORE_RF_BYPASS_EN`, `rs1_data`=0xA5A5A5A5 that cycle. Without it, `rs1_data` shows the old value that cycle and the new value the next cycle.
